// File: rtl/kmap_sweep_checker_pkg.sv
// Shared constants and state encoding for the K-map sweep checker.
package kmap_sweep_checker_pkg;
  localparam int          NVEC           = 16;
  localparam logic [3:0]  FIRST_ERR_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/kmap_sweep_checker_dwell_timer.sv
// Per-vector dwell counter: sample_o fires on the edge f is captured,
// tick_o on the following edge, when the next vector is driven.
module kmap_dwell_timer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o,
  output logic sample_o
);
  logic [CNT_W-1:0] cnt_q;

  assign tick_o   = (cnt_q == CNT_W'(DWELL - 1));
  assign sample_o = (cnt_q == CNT_W'(DWELL - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/kmap_sweep_checker.sv
// Drives all 16 minterms into a 4-input K-map block, captures f per vector,
// and scores the measured table against a latched expected mask.
module kmap_sweep_checker
  import kmap_sweep_checker_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] expected_i,
  input  logic        f_i,
  output logic        a_o,
  output logic        b_o,
  output logic        c_o,
  output logic        d_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] truth_o,
  output logic [4:0]  ones_count_o,
  output logic [4:0]  err_count_o,
  output logic [3:0]  first_err_o,
  output logic        err_valid_o
);
  state_e      state_q;
  logic [3:0]  idx_q;
  logic [15:0] exp_q;
  logic [15:0] truth_q;
  logic [4:0]  ones_q;
  logic [4:0]  err_q;
  logic [3:0]  first_q;
  logic        evalid_q;
  logic        busy_q;
  logic        done_q;

  logic accept_d;
  logic mism_d;
  logic tick;
  logic sample;

  // Start is only honoured outside RUN, so a start on the final sample edge is dropped.
  assign accept_d = start_i && (state_q != S_RUN);
  assign mism_d   = f_i ^ exp_q[idx_q];

  kmap_dwell_timer #(.DWELL(DWELL), .CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept_d),
    .en_i     (state_q == S_RUN),
    .tick_o   (tick),
    .sample_o (sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      exp_q    <= '0;
      truth_q  <= '0;
      ones_q   <= '0;
      err_q    <= '0;
      first_q  <= FIRST_ERR_NONE;
      evalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q  <= S_RUN;
            idx_q    <= '0;
            exp_q    <= expected_i;
            truth_q  <= '0;
            ones_q   <= '0;
            err_q    <= '0;
            first_q  <= FIRST_ERR_NONE;
            evalid_q <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (sample) begin
            truth_q[idx_q] <= f_i;
            ones_q         <= ones_q + 5'(f_i);
            if (mism_d) begin
              err_q <= err_q + 5'd1;
              if (!evalid_q) begin
                first_q  <= idx_q;
                evalid_q <= 1'b1;
              end
            end
            // Last vector stays on a..d through DONE.
            if (idx_q == 4'(NVEC - 1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          if (tick) idx_q <= idx_q + 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {a_o, b_o, c_o, d_o} = idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign truth_o      = truth_q;
  assign ones_count_o = ones_q;
  assign err_count_o  = err_q;
  assign first_err_o  = first_q;
  assign err_valid_o  = evalid_q;
endmodule
